trace_merge_arbiter: RTL and testbench

Merges the trace record streams of `NUM_SOURCES` instrumented shells into one trace output stream. Arbitration is round-robin with bounded bursts, and each record is tagged with its source index. The block sits between the per-shell trace outputs and the single trace sink (readout FIFO or DMA). It also keeps per-source forwarded-record counters.

---
 rtl/trace_merge_arbiter.sv | 134 +++++++++++++
 tb/tb_trace_merge_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_merge_arbiter.sv
// Merges NUM_SOURCES trace streams into one tagged stream: round-robin with bounded bursts.
// Latency: one cycle from source accept to out_valid through a single output register.
// Backpressure: out_ready low freezes arbitration and holds the output record; src_ready stays low.

package trace_pkg;
    localparam int TRACE_RECORD_WIDTH = 32;
endpackage

module trace_merge_arbiter #(
    parameter int NUM_SOURCES  = 4,
    parameter int RECORD_WIDTH = trace_pkg::TRACE_RECORD_WIDTH,
    parameter int MAX_BURST    = 4,
    localparam int SRC_ID_WIDTH = $clog2(NUM_SOURCES)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SOURCES-1:0]              src_enable,
    input  logic [NUM_SOURCES-1:0]              src_valid,
    output logic [NUM_SOURCES-1:0]              src_ready,
    input  logic [NUM_SOURCES*RECORD_WIDTH-1:0] src_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RECORD_WIDTH-1:0]             out_data,
    output logic [SRC_ID_WIDTH-1:0]             out_src_id,
    output logic [NUM_SOURCES*32-1:0]           grant_count,
    output logic                                arb_idle
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [SRC_ID_WIDTH-1:0]  owner;
    logic [BURST_W-1:0]       burst_cnt;
    logic [NUM_SOURCES-1:0]   eligible;
    logic                     slot_open;
    logic                     win_vld;
    logic [SRC_ID_WIDTH-1:0]  win_id;
    logic                     xfer;
    int                       idx;

    assign eligible  = src_valid & src_enable;
    assign slot_open = !out_valid || out_ready;
    assign xfer      = slot_open && win_vld;

    // Owner keeps the grant until its burst is spent; the search visits owner last.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (state_q == HOLD && eligible[owner] && burst_cnt < BURST_W'(MAX_BURST)) begin
            win_vld = 1'b1;
            win_id  = owner;
        end else begin
            for (int k = 1; k <= NUM_SOURCES; k++) begin
                idx = (int'(owner) + k) % NUM_SOURCES;
                if (!win_vld && eligible[idx[SRC_ID_WIDTH-1:0]]) begin
                    win_vld = 1'b1;
                    win_id  = idx[SRC_ID_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (slot_open) begin
            state_d = win_vld ? HOLD : IDLE;
        end
    end

    always_comb begin
        src_ready = '0;
        if (rst_n && xfer) begin
            src_ready[win_id] = 1'b1;
        end
        arb_idle = (state_q == IDLE) && !out_valid;
    end

    // Owner doubles as the round-robin pointer, so it is retained through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= SRC_ID_WIDTH'(NUM_SOURCES - 1);
            burst_cnt <= '0;
        end else if (xfer) begin
            if (state_q == HOLD && win_id == owner) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end else begin
                owner     <= win_id;
                burst_cnt <= BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src_id <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= src_data[int'(win_id)*RECORD_WIDTH +: RECORD_WIDTH];
            out_src_id <= win_id;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (xfer && win_id == SRC_ID_WIDTH'(i)) begin
                    grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_merge_arbiter.sv
// Directed bench for trace_merge_arbiter: expected records queued per step, compared as they drain.
module tb_trace_merge_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   src_enable;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [127:0] src_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_src_id;
    logic [127:0] grant_count;
    logic         arb_idle;

    logic [3:0]   src_enable_rr;
    logic [3:0]   src_valid_rr;
    logic [3:0]   src_ready_rr;
    logic [127:0] src_data_rr;
    logic         out_valid_rr;
    logic         out_ready_rr;
    logic [31:0]  out_data_rr;
    logic [1:0]   out_src_id_rr;
    logic [127:0] grant_count_rr;
    logic         arb_idle_rr;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   seq [4];
    int   eseq[4];
    int   passed;
    int   total;
    logic [1:0] rr_exp [4];

    trace_merge_arbiter #(.NUM_SOURCES(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .src_enable(src_enable), .src_valid(src_valid),
        .src_ready(src_ready), .src_data(src_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src_id(out_src_id),
        .grant_count(grant_count), .arb_idle(arb_idle)
    );

    trace_merge_arbiter #(.NUM_SOURCES(4), .MAX_BURST(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .src_enable(src_enable_rr), .src_valid(src_valid_rr),
        .src_ready(src_ready_rr), .src_data(src_data_rr), .out_valid(out_valid_rr),
        .out_ready(out_ready_rr), .out_data(out_data_rr), .out_src_id(out_src_id_rr),
        .grant_count(grant_count_rr), .arb_idle(arb_idle_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic upd_data();
        for (int i = 0; i < 4; i++) begin
            src_data[i*32 +: 32] = {8'(i), 24'(seq[i])};
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = {8'(id), 24'(eseq[id])};
        eseq[id]++;
        q.push_back(e);
    endtask

    // Samples mid-cycle, retires any delivered record, then advances to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            chk("record_expected", 128'(q.size() > 0), 128'(1));
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_src_id", 128'(out_src_id), 128'(e.id));
                chk("out_data", 128'(out_data), 128'(e.data));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (src_ready[i]) seq[i]++;
        end
        @(negedge clk);
        upd_data();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_src_ready", 128'(src_ready), 128'(0));
        chk("rst_rr_out_valid", 128'(out_valid_rr), 128'(0));
        repeat (3) @(negedge clk);
        chk("rst_arb_idle", 128'(arb_idle), 128'(1));
        chk("rst_counts", grant_count, 128'(0));
        chk("rst_src_ready_held", 128'(src_ready), 128'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            eseq[i] = 0;
        end
        q.delete();
        upd_data();
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst_n         = 1'b1;
        src_enable    = 4'hF;
        src_valid     = 4'hF;
        out_ready     = 1'b1;
        src_enable_rr = 4'hF;
        src_valid_rr  = 4'h0;
        out_ready_rr  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            eseq[i] = 0;
            src_data_rr[i*32 +: 32] = {8'(i), 24'd0};
        end
        rr_exp[0] = 2'd0;
        rr_exp[1] = 2'd3;
        rr_exp[2] = 2'd0;
        rr_exp[3] = 2'd3;
        upd_data();
        @(negedge clk);
        do_reset();

        // Fair rotation: four sources, bursts of four
        for (int i = 0; i < 17; i++) push_exp(i < 16 ? i / 4 : 0);
        for (int c = 0; c < 19; c++) begin
            src_valid = (c < 17) ? 4'hF : 4'h0;
            #1;
            if (c == 0) chk("first_grant_src0", 128'(src_ready), 128'(4'b0001));
            if (c >= 1 && c <= 17) chk("fair_no_bubble", 128'(out_valid), 128'(1));
            if (c == 16) chk("fair_counts", grant_count, {4{32'd4}});
            if (c == 18) begin
                chk("fair_idle", 128'(arb_idle), 128'(1));
                chk("fair_sb_empty", 128'(q.size()), 128'(0));
            end
            tick();
        end

        // Single source: burst re-win without bubbles
        src_valid = 4'h0;
        do_reset();
        for (int i = 0; i < 10; i++) push_exp(2);
        for (int c = 0; c < 12; c++) begin
            src_valid = (c < 10) ? 4'b0100 : 4'h0;
            #1;
            if (c >= 1 && c <= 10) chk("single_no_bubble", 128'(out_valid), 128'(1));
            if (c == 11) begin
                chk("single_count2", 128'(grant_count[95:64]), 128'(10));
                chk("single_idle", 128'(arb_idle), 128'(1));
                chk("single_sb_empty", 128'(q.size()), 128'(0));
            end
            tick();
        end

        // Backpressure holds record and burst position
        do_reset();
        for (int i = 0; i < 8; i++) push_exp(i < 4 ? 0 : 1);
        for (int c = 0; c < 15; c++) begin
            src_valid = (c <= 12) ? 4'b0011 : 4'h0;
            out_ready = !(c >= 2 && c <= 6);
            #1;
            if (c >= 2 && c <= 6) begin
                chk("bp_out_valid", 128'(out_valid), 128'(1));
                chk("bp_src_id", 128'(out_src_id), 128'(0));
                chk("bp_data", 128'(out_data), 128'({8'd0, 24'd1}));
                chk("bp_src_ready", 128'(src_ready), 128'(0));
                chk("bp_burst_cnt", 128'(dut.burst_cnt), 128'(2));
            end
            if (c == 14) begin
                chk("bp_sb_empty", 128'(q.size()), 128'(0));
                chk("bp_idle", 128'(arb_idle), 128'(1));
            end
            tick();
        end
        out_ready = 1'b1;

        // Enable drop ends source 1's burst
        do_reset();
        push_exp(1);
        push_exp(1);
        push_exp(2);
        push_exp(2);
        for (int c = 0; c < 6; c++) begin
            src_valid  = (c <= 3) ? 4'b0110 : 4'h0;
            src_enable = (c >= 2) ? 4'b1101 : 4'hF;
            #1;
            if (c == 2) chk("drop_grant_src2", 128'(src_ready), 128'(4'b0100));
            if (c == 5) begin
                chk("drop_count1", 128'(grant_count[63:32]), 128'(2));
                chk("drop_count2", 128'(grant_count[95:64]), 128'(2));
                chk("drop_sb_empty", 128'(q.size()), 128'(0));
            end
            tick();
        end
        src_enable = 4'hF;

        // Reset while a record sits in the output register
        src_valid = 4'hF;
        push_exp(0);
        tick();
        src_valid = 4'h0;
        do_reset();

        // Pure round-robin with MAX_BURST=1
        src_valid_rr = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) src_valid_rr = 4'h0;
            #1;
            if (c >= 1) begin
                chk("rr_out_valid", 128'(out_valid_rr), 128'(1));
                chk("rr_src_id", 128'(out_src_id_rr), 128'(rr_exp[c-1]));
                chk("rr_data", 128'(out_data_rr), 128'({6'd0, rr_exp[c-1], 24'd0}));
            end
            tick();
        end

        // Counter wrap
        force dut.grant_count = {96'd0, 32'hFFFF_FFFF};
        #1;
        release dut.grant_count;
        chk("wrap_preset", 128'(grant_count[31:0]), 128'(32'hFFFF_FFFF));
        push_exp(0);
        src_valid = 4'b0001;
        tick();
        src_valid = 4'h0;
        tick();
        #1;
        chk("wrap_count0", 128'(grant_count[31:0]), 128'(0));
        chk("wrap_count1", 128'(grant_count[63:32]), 128'(0));
        chk("wrap_sb_empty", 128'(q.size()), 128'(0));
        chk("wrap_idle", 128'(arb_idle), 128'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
